mem_wb_stage: RTL

//  Memory stage plus M/WB pipeline register; consumes the Ex/M latch outputs. Holds data memory and stack pointer.

---
 rtl/mem_wb_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory stage plus M/WB pipeline register: data memory, stack pointer and write-back latch.
// Optional stack overflow/underflow guard enabled by defining STACK_GUARD_EN.
module mem_wb_stage #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned REG_AW = 2,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld,
    input  logic              flush,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [REG_AW-1:0] in_rb,
    input  logic [DATA_W-1:0] in_R_ra,
    input  logic [DATA_W-1:0] in_R_rb,
    input  logic [DATA_W-1:0] in_res,
    input  logic              in_RW,
    input  logic              in_SW1,
    input  logic              in_SW2,
    input  logic              in_out_ld,
    input  logic              in_Hlt,
    input  logic [1:0]        in_SP,
    input  logic              in_MW,
    input  logic              in_SM1,
    input  logic              in_SM2,
    output logic [REG_AW-1:0] wb_ra,
    output logic [REG_AW-1:0] wb_rb,
    output logic [DATA_W-1:0] wb_R_rb,
    output logic [DATA_W-1:0] wb_res,
    output logic [DATA_W-1:0] wb_mem,
    output logic              wb_RW,
    output logic              wb_SW1,
    output logic              wb_SW2,
    output logic              wb_out_ld,
    output logic              wb_Hlt,
    output logic [ADDR_W-1:0] sp_val,
    output logic              stk_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [REG_AW-1:0] wb_ra_q, wb_ra_d;
    logic [REG_AW-1:0] wb_rb_q, wb_rb_d;
    logic [DATA_W-1:0] wb_R_rb_q, wb_R_rb_d;
    logic [DATA_W-1:0] wb_res_q, wb_res_d;
    logic [DATA_W-1:0] wb_mem_q, wb_mem_d;
    logic              wb_RW_q, wb_RW_d;
    logic              wb_SW1_q, wb_SW1_d;
    logic              wb_SW2_q, wb_SW2_d;
    logic              wb_out_ld_q, wb_out_ld_d;
    logic              wb_Hlt_q, wb_Hlt_d;
    logic [ADDR_W-1:0] sp_q, sp_d;

    logic              push_c, pop_c, commit_c, fault_c, mem_we_c;
    logic [ADDR_W-1:0] stk_addr_c, addr_c;
    logic [DATA_W-1:0] wdata_c;

    // Address / data selection for the memory access of the current instruction
    always_comb begin
        push_c     = (in_SP == 2'b01);
        pop_c      = (in_SP == 2'b10);
        commit_c   = ld & ~flush;
        stk_addr_c = pop_c ? (sp_q + ADDR_W'(1)) : sp_q;
        addr_c     = in_SM1 ? stk_addr_c : in_res[ADDR_W-1:0];
        wdata_c    = in_SM2 ? in_R_ra : in_R_rb;
    end

`ifdef STACK_GUARD_EN
    logic stk_err_q, stk_err_d;

    assign fault_c = (push_c && (sp_q == '0)) || (pop_c && (sp_q == '1));
    assign stk_err = stk_err_q;

    always_comb begin
        stk_err_d = stk_err_q | (commit_c & fault_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stk_err_q <= 1'b0;
        end else begin
            stk_err_q <= stk_err_d;
        end
    end
`else
    assign fault_c = 1'b0;
    assign stk_err = 1'b0;
`endif

    assign mem_we_c = commit_c & in_MW & ~fault_c;

    // Next-state for the write-back latch and stack pointer; flush beats stall
    always_comb begin
        wb_ra_d     = wb_ra_q;
        wb_rb_d     = wb_rb_q;
        wb_R_rb_d   = wb_R_rb_q;
        wb_res_d    = wb_res_q;
        wb_mem_d    = wb_mem_q;
        wb_RW_d     = wb_RW_q;
        wb_SW1_d    = wb_SW1_q;
        wb_SW2_d    = wb_SW2_q;
        wb_out_ld_d = wb_out_ld_q;
        wb_Hlt_d    = wb_Hlt_q;
        sp_d        = sp_q;

        if (flush) begin
            wb_ra_d     = '0;
            wb_rb_d     = '0;
            wb_R_rb_d   = '0;
            wb_res_d    = '0;
            wb_mem_d    = '0;
            wb_RW_d     = 1'b0;
            wb_SW1_d    = 1'b0;
            wb_SW2_d    = 1'b0;
            wb_out_ld_d = 1'b0;
            wb_Hlt_d    = 1'b0;
        end else if (ld) begin
            wb_ra_d     = in_ra;
            wb_rb_d     = in_rb;
            wb_R_rb_d   = in_R_rb;
            wb_res_d    = in_res;
            wb_mem_d    = mem_q[addr_c];
            wb_RW_d     = in_RW & ~fault_c;
            wb_SW1_d    = in_SW1;
            wb_SW2_d    = in_SW2;
            wb_out_ld_d = in_out_ld;
            wb_Hlt_d    = in_Hlt;
            if (!fault_c) begin
                if (push_c) begin
                    sp_d = sp_q - ADDR_W'(1);
                end else if (pop_c) begin
                    sp_d = sp_q + ADDR_W'(1);
                end
            end
        end
    end

    // Memory shares the reset branch so a write coinciding with reset is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_ra_q     <= '0;
            wb_rb_q     <= '0;
            wb_R_rb_q   <= '0;
            wb_res_q    <= '0;
            wb_mem_q    <= '0;
            wb_RW_q     <= 1'b0;
            wb_SW1_q    <= 1'b0;
            wb_SW2_q    <= 1'b0;
            wb_out_ld_q <= 1'b0;
            wb_Hlt_q    <= 1'b0;
            sp_q        <= SP_INIT;
        end else begin
            wb_ra_q     <= wb_ra_d;
            wb_rb_q     <= wb_rb_d;
            wb_R_rb_q   <= wb_R_rb_d;
            wb_res_q    <= wb_res_d;
            wb_mem_q    <= wb_mem_d;
            wb_RW_q     <= wb_RW_d;
            wb_SW1_q    <= wb_SW1_d;
            wb_SW2_q    <= wb_SW2_d;
            wb_out_ld_q <= wb_out_ld_d;
            wb_Hlt_q    <= wb_Hlt_d;
            sp_q        <= sp_d;
            if (mem_we_c) begin
                mem_q[addr_c] <= wdata_c;
            end
        end
    end

    assign wb_ra     = wb_ra_q;
    assign wb_rb     = wb_rb_q;
    assign wb_R_rb   = wb_R_rb_q;
    assign wb_res    = wb_res_q;
    assign wb_mem    = wb_mem_q;
    assign wb_RW     = wb_RW_q;
    assign wb_SW1    = wb_SW1_q;
    assign wb_SW2    = wb_SW2_q;
    assign wb_out_ld = wb_out_ld_q;
    assign wb_Hlt    = wb_Hlt_q;
    assign sp_val    = sp_q;

endmodule
